// File: rtl/blake2_core.sv
// blake2_core: iterative BLAKE2 compression engine (W=64 BLAKE2b, W=32 BLAKE2s), one G per cycle.
// Latency: accept -> valid_o in 8R+2 cycles (98 for b, 82 for s); one block per 8R+2 cycles.
// Backpressure: ready_o is low while a block is in flight; valid_o is a one-cycle pulse with no backpressure.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_i / ready_o   block handshake; block held by the source until accepted
//   first_i, last_i     message framing of the offered block
//   len_i               byte count of a last block (0..BB)
//   kk_i, nn_i          key / digest length, used when a block starts a chain
//   d_i                 message words m[0..15], m[i] = d_i[W*i +: W]
//   valid_o, h_o        final-state pulse and chained state h[0..7]
//
// Optional feature macro: BLAKE2_KEYED_EN (folds kk_i into the parameter word of h0).
module blake2_core #(
  parameter int W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              first_i,
  input  logic              last_i,
  input  logic [7:0]        len_i,
  input  logic [7:0]        kk_i,
  input  logic [7:0]        nn_i,
  input  logic [16*W-1:0]   d_i,
  output logic              valid_o,
  output logic [8*W-1:0]    h_o
);

  localparam int BB = 2 * W;
  localparam int R  = (W == 64) ? 12 : 10;
  localparam int R1 = (W == 64) ? 32 : 16;
  localparam int R2 = (W == 64) ? 24 : 12;
  localparam int R3 = (W == 64) ? 16 : 8;
  localparam int R4 = (W == 64) ? 63 : 7;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  // The BLAKE2s IV is the upper half of each BLAKE2b IV word.
  function automatic logic [W-1:0] iv(input int i);
    logic [63:0] x;
    case (i)
      0:       x = 64'h6A09E667F3BCC908;
      1:       x = 64'hBB67AE8584CAA73B;
      2:       x = 64'h3C6EF372FE94F82B;
      3:       x = 64'hA54FF53A5F1D36F1;
      4:       x = 64'h510E527FADE682D1;
      5:       x = 64'h9B05688C2B3E6C1F;
      6:       x = 64'h1F83D9ABFB41BD6B;
      default: x = 64'h5BE0CD19137E2179;
    endcase
    return x[63 -: W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  // Message permutation; rows 10 and 11 (BLAKE2b only) reuse rows 0 and 1.
  // Each row is packed with element 0 in the most significant nibble.
  function automatic logic [3:0] sigma(input logic [3:0] r, input logic [3:0] j);
    logic [63:0] row;
    case (r)
      4'd1, 4'd11: row = 64'hEA489FD61C02B753;
      4'd2:        row = 64'hB8C052FDAE367194;
      4'd3:        row = 64'h7931DCBE265A40F8;
      4'd4:        row = 64'h905724AFE1BC683D;
      4'd5:        row = 64'h2C6A0B834D75FE19;
      4'd6:        row = 64'hC51FED4A0763928B;
      4'd7:        row = 64'hDB7EC13950F4862A;
      4'd8:        row = 64'h6FE9B308C2D714A5;
      4'd9:        row = 64'hA2847615FB9E3CD0;
      default:     row = 64'h0123456789ABCDEF;
    endcase
    return row[4 * (15 - int'(j)) +: 4];
  endfunction

  state_t          state;
  logic [W-1:0]    h_q [8];
  logic [W-1:0]    v_q [16];
  logic [W-1:0]    m_q [16];
  logic [2*W-1:0]  t_q;
  logic            chain_q;
  logic            last_q;
  logic [2:0]      g_q;
  logic [3:0]      r_q;

  // ---------------- block start: counter, parameter word, initial v ----------------
  logic            accept;
  logic            start;
  logic [7:0]      len_c;
  logic [2*W-1:0]  inc;
  logic [2*W-1:0]  t_new;
  logic [W-1:0]    pw;
  logic [W-1:0]    h_init [8];
  logic [W-1:0]    v_init [16];

  assign accept = valid_i & ready_o;
  // A block arriving with no chain in progress (after reset) starts a new message.
  assign start  = first_i | ~chain_q;
  assign len_c  = (len_i > 8'(BB)) ? 8'(BB) : len_i;
  assign inc    = last_i ? (2*W)'(len_c) : (2*W)'(BB);
  assign t_new  = (start ? '0 : t_q) + inc;

`ifdef BLAKE2_KEYED_EN
  assign pw = W'(32'h0101_0000) ^ W'({kk_i, 8'h00}) ^ W'(nn_i);
`else
  logic unused_kk;
  assign unused_kk = ^kk_i;
  assign pw = W'(32'h0101_0000) ^ W'(nn_i);
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      h_init[i] = start ? iv(i) : h_q[i];
    end
    if (start) h_init[0] = h_init[0] ^ pw;
    for (int i = 0; i < 8; i++) begin
      v_init[i]     = h_init[i];
      v_init[i + 8] = iv(i);
    end
    v_init[12] = v_init[12] ^ t_new[W-1:0];
    v_init[13] = v_init[13] ^ t_new[2*W-1:W];
    if (last_i) v_init[14] = ~v_init[14];
  end

  // ---------------- one G function per cycle ----------------
  logic [3:0]   ia, ib, ic, id;
  logic [W-1:0] x, y;
  logic [W-1:0] ga, gb, gc, gd;

  // g=0..3 are the columns, g=4..7 the diagonals.
  always_comb begin
    case (g_q)
      3'd0:    {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8,  4'd12};
      3'd1:    {ia, ib, ic, id} = {4'd1, 4'd5, 4'd9,  4'd13};
      3'd2:    {ia, ib, ic, id} = {4'd2, 4'd6, 4'd10, 4'd14};
      3'd3:    {ia, ib, ic, id} = {4'd3, 4'd7, 4'd11, 4'd15};
      3'd4:    {ia, ib, ic, id} = {4'd0, 4'd5, 4'd10, 4'd15};
      3'd5:    {ia, ib, ic, id} = {4'd1, 4'd6, 4'd11, 4'd12};
      3'd6:    {ia, ib, ic, id} = {4'd2, 4'd7, 4'd8,  4'd13};
      default: {ia, ib, ic, id} = {4'd3, 4'd4, 4'd9,  4'd14};
    endcase
  end

  assign x = m_q[sigma(r_q, {g_q, 1'b0})];
  assign y = m_q[sigma(r_q, {g_q, 1'b1})];

  always_comb begin
    ga = v_q[ia];
    gb = v_q[ib];
    gc = v_q[ic];
    gd = v_q[id];
    ga = ga + gb + x;
    gd = rotr(gd ^ ga, R1);
    gc = gc + gd;
    gb = rotr(gb ^ gc, R2);
    ga = ga + gb + y;
    gd = rotr(gd ^ ga, R3);
    gc = gc + gd;
    gb = rotr(gb ^ gc, R4);
  end

  // ---------------- control and state ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      t_q     <= '0;
      chain_q <= 1'b0;
      last_q  <= 1'b0;
      g_q     <= '0;
      r_q     <= '0;
      for (int i = 0; i < 8; i++)  h_q[i] <= '0;
      for (int i = 0; i < 16; i++) begin
        v_q[i] <= '0;
        m_q[i] <= '0;
      end
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= ROUND;
            ready_o <= 1'b0;
            chain_q <= 1'b1;
            last_q  <= last_i;
            t_q     <= t_new;
            g_q     <= '0;
            r_q     <= '0;
            for (int i = 0; i < 8; i++)  h_q[i] <= h_init[i];
            for (int i = 0; i < 16; i++) begin
              v_q[i] <= v_init[i];
              m_q[i] <= d_i[W*i +: W];
            end
          end
        end
        ROUND: begin
          v_q[ia] <= ga;
          v_q[ib] <= gb;
          v_q[ic] <= gc;
          v_q[id] <= gd;
          if (g_q == 3'd7) begin
            g_q <= '0;
            if (r_q == 4'(R - 1)) state <= FINAL;
            else                  r_q   <= r_q + 4'd1;
          end else begin
            g_q <= g_q + 3'd1;
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] ^ v_q[i] ^ v_q[i + 8];
          state   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= last_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_hout
    assign h_o[W*i +: W] = h_q[i];
  end

endmodule

// File: tb/tb_blake2_core.sv
// Directed bench for blake2_core: BLAKE2b (W=64) and BLAKE2s (W=32) instances side by side.
// Fixed digests come from published BLAKE2 vectors; multi-block and keyed cases use a reference model.
module tb_blake2_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // BLAKE2b instance
  logic         valid_b, ready_b, first_b, last_b, vout_b;
  logic [7:0]   len_b, kk_b, nn_b;
  logic [1023:0] d_b;
  logic [511:0] h_b;

  // BLAKE2s instance
  logic         valid_s, ready_s, first_s, last_s, vout_s;
  logic [7:0]   len_s, kk_s, nn_s;
  logic [511:0] d_s;
  logic [255:0] h_s;

  blake2_core #(.W(64)) dut_b (
    .clk(clk), .reset(reset), .valid_i(valid_b), .ready_o(ready_b),
    .first_i(first_b), .last_i(last_b), .len_i(len_b), .kk_i(kk_b), .nn_i(nn_b),
    .d_i(d_b), .valid_o(vout_b), .h_o(h_b)
  );

  blake2_core #(.W(32)) dut_s (
    .clk(clk), .reset(reset), .valid_i(valid_s), .ready_o(ready_s),
    .first_i(first_s), .last_i(last_s), .len_i(len_s), .kk_i(kk_s), .nn_i(nn_s),
    .d_i(d_s), .valid_o(vout_s), .h_o(h_s)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference BLAKE2b model ----------------
  localparam logic [63:0] IV [8] = '{
    64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
    64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};

  localparam int SIG [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};

  localparam int GI [8][4] = '{
    '{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

  function automatic logic [63:0] rotr64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [255:0] gmix(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c, input logic [63:0] d,
                                        input logic [63:0] mx, input logic [63:0] my);
    a = a + b + mx;  d = rotr64(d ^ a, 32);
    c = c + d;       b = rotr64(b ^ c, 24);
    a = a + b + my;  d = rotr64(d ^ a, 16);
    c = c + d;       b = rotr64(b ^ c, 63);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] mdl_init(input logic [7:0] kk, input logic [7:0] nn);
    logic [511:0] h;
    for (int i = 0; i < 8; i++) h[64*i +: 64] = IV[i];
    h[63:0] = h[63:0] ^ 64'h01010000 ^ {48'h0, kk, 8'h0} ^ {56'h0, nn};
    return h;
  endfunction

  function automatic logic [511:0] mdl_compress(input logic [511:0] h, input logic [1023:0] m,
                                                input logic [127:0] t, input bit last);
    logic [63:0]  v [16];
    logic [63:0]  mw [16];
    logic [255:0] q;
    logic [511:0] o;
    for (int i = 0; i < 16; i++) mw[i] = m[64*i +: 64];
    for (int i = 0; i < 8; i++) begin
      v[i]     = h[64*i +: 64];
      v[i + 8] = IV[i];
    end
    v[12] = v[12] ^ t[63:0];
    v[13] = v[13] ^ t[127:64];
    if (last) v[14] = ~v[14];
    for (int r = 0; r < 12; r++) begin
      for (int g = 0; g < 8; g++) begin
        q = gmix(v[GI[g][0]], v[GI[g][1]], v[GI[g][2]], v[GI[g][3]],
                 mw[SIG[r % 10][2*g]], mw[SIG[r % 10][2*g + 1]]);
        v[GI[g][0]] = q[255:192];
        v[GI[g][1]] = q[191:128];
        v[GI[g][2]] = q[127:64];
        v[GI[g][3]] = q[63:0];
      end
    end
    for (int i = 0; i < 8; i++) o[64*i +: 64] = h[64*i +: 64] ^ v[i] ^ v[i + 8];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers one block to the BLAKE2b instance. Cycle 0 is the cycle in which valid and ready
  // are both high; lat_v / lat_r are the cycle numbers where valid_o / ready_o are first seen
  // afterwards (-1 if never within the bound).
  task automatic send_b(input bit first, input bit last, input logic [7:0] len,
                        input logic [7:0] kk, input logic [7:0] nn, input logic [1023:0] d,
                        output int lat_v, output int lat_r);
    int n;
    n = 0;
    while (ready_b !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    first_b = first; last_b = last; len_b = len; kk_b = kk; nn_b = nn; d_b = d;
    valid_b = 1'b1;
    lat_v = -1;
    lat_r = -1;
    tick();
    valid_b = 1'b0;
    n = 1;
    while (n < 200 && lat_r < 0) begin
      tick();
      n++;
      if (vout_b === 1'b1 && lat_v < 0) lat_v = n;
      if (ready_b === 1'b1) lat_r = n;
    end
  endtask

  logic [1023:0] abc_b, blk0, blk1, key_blk;
  logic [511:0]  exp_h;
  logic [7:0]    kk_model;
  int            lv, lr, n;

  initial begin
    reset = 1'b1;
    valid_b = 1'b0; first_b = 1'b0; last_b = 1'b0; len_b = '0; kk_b = '0; nn_b = '0; d_b = '0;
    valid_s = 1'b0; first_s = 1'b0; last_s = 1'b0; len_s = '0; kk_s = '0; nn_s = '0; d_s = '0;
    abc_b = '0;
    abc_b[23:0] = 24'h636261;
    blk0 = '0;
    blk1 = '0;
    key_blk = '0;
    for (int j = 0; j < 128; j++) blk0[8*j +: 8] = 8'(j * 7 + 1);
    for (int j = 0; j < 72; j++)  blk1[8*j +: 8] = 8'((128 + j) * 7 + 1);
    for (int j = 0; j < 64; j++)  key_blk[8*j +: 8] = 8'(j);

    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_ready", 512'(ready_b), 512'(1));
    chk("rst_valid", 512'(vout_b), 512'(0));
    chk("rst_h_b", h_b, 512'(0));
    chk("rst_h_s", 512'(h_s), 512'(0));

    // BLAKE2b-512("abc")
    send_b(1'b1, 1'b1, 8'd3, 8'd0, 8'd64, abc_b, lv, lr);
    chk("abc_b_latency", 512'(lv), 512'(98));
    chk("abc_b_h0", 512'(h_b[63:0]), 512'(64'h0D4D1C983FA580BA));
    chk("abc_b_h1", 512'(h_b[127:64]), 512'(64'hE9F6129FB697276A));

    // BLAKE2b-512 of the empty message
    send_b(1'b1, 1'b1, 8'd0, 8'd0, 8'd64, 1024'(0), lv, lr);
    chk("empty_b_latency", 512'(lv), 512'(98));
    chk("empty_b_h0", 512'(h_b[63:0]), 512'(64'h03590142F7026A78));
    chk("empty_b_h1", 512'(h_b[127:64]), 512'(64'h72D2522585FDC6C6));
    chk("empty_b_t", 512'(dut_b.t_q), 512'(0));

    // BLAKE2s-256("abc")
    first_s = 1'b1; last_s = 1'b1; len_s = 8'd3; nn_s = 8'd32;
    d_s = '0;
    d_s[23:0] = 24'h636261;
    valid_s = 1'b1;
    lv = -1;
    tick();
    valid_s = 1'b0;
    n = 1;
    while (n < 200 && lv < 0) begin
      tick();
      n++;
      if (vout_s === 1'b1) lv = n;
    end
    chk("abc_s_latency", 512'(lv), 512'(82));
    chk("abc_s_h0", 512'(h_s[31:0]), 512'(32'h8C5E8C50));
    chk("abc_s_h1", 512'(h_s[63:32]), 512'(32'hE2147C32));

    // 200-byte message over two blocks
    send_b(1'b1, 1'b0, 8'd128, 8'd0, 8'd64, blk0, lv, lr);
    chk("m200_blk0_no_valid", 512'(lv), 512'(-1));
    chk("m200_blk0_ready", 512'(lr), 512'(98));
    send_b(1'b0, 1'b1, 8'd72, 8'd0, 8'd64, blk1, lv, lr);
    exp_h = mdl_init(8'd0, 8'd64);
    exp_h = mdl_compress(exp_h, blk0, 128'd128, 1'b0);
    exp_h = mdl_compress(exp_h, blk1, 128'd200, 1'b1);
    chk("m200_latency", 512'(lv), 512'(98));
    chk("m200_digest", h_b, exp_h);
    chk("m200_t", 512'(dut_b.t_q), 512'(200));

    // first_i on a later block restarts the chain
    send_b(1'b1, 1'b0, 8'd128, 8'd0, 8'd64, blk0, lv, lr);
    send_b(1'b1, 1'b1, 8'd3, 8'd0, 8'd64, abc_b, lv, lr);
    chk("restart_h0", 512'(h_b[63:0]), 512'(64'h0D4D1C983FA580BA));

    // Reset in the middle of a block
    first_b = 1'b1; last_b = 1'b1; len_b = 8'd3; nn_b = 8'd64; d_b = abc_b;
    valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    repeat (39) tick();
    reset = 1'b1;
    tick();
    chk("midrst_ready", 512'(ready_b), 512'(1));
    chk("midrst_valid", 512'(vout_b), 512'(0));
    chk("midrst_chain", 512'(dut_b.chain_q), 512'(0));
    reset = 1'b0;
    tick();
    send_b(1'b0, 1'b1, 8'd3, 8'd0, 8'd64, abc_b, lv, lr);
    chk("midrst_abc_latency", 512'(lv), 512'(98));
    chk("midrst_abc_h0", 512'(h_b[63:0]), 512'(64'h0D4D1C983FA580BA));
    chk("midrst_abc_h1", 512'(h_b[127:64]), 512'(64'hE9F6129FB697276A));

    // Key block then "abc"; kk only folds in when the keyed build is enabled
`ifdef BLAKE2_KEYED_EN
    kk_model = 8'd64;
`else
    kk_model = 8'd0;
`endif
    send_b(1'b1, 1'b0, 8'd128, 8'd64, 8'd64, key_blk, lv, lr);
    send_b(1'b0, 1'b1, 8'd3, 8'd64, 8'd64, abc_b, lv, lr);
    exp_h = mdl_init(kk_model, 8'd64);
    exp_h = mdl_compress(exp_h, key_blk, 128'd128, 1'b0);
    exp_h = mdl_compress(exp_h, abc_b, 128'd131, 1'b1);
    chk("keyed_digest", h_b, exp_h);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blake2_core.md
# blake2_core

Iterative, parametrised BLAKE2 compression engine with full multi-block chaining. `W` selects the variant: BLAKE2b when `W=64`, BLAKE2s when `W=32`. The engine accepts one 16-word message block per valid/ready handshake and keeps the chained state `h` and the byte offset `t` internally. It executes one G function per cycle and emits the final state when it finishes the last block of a message. It sits between the message padder/packer upstream and the digest truncation/output stage downstream.

## Interface
Parameters:
- `W`, 64, word width; 64 = BLAKE2b, 32 = BLAKE2s. Other values are illegal.
- `BB`, `2*W`, block size in bytes (localparam).
- `R`, 12 if W=64 else 10, round count (localparam).
- `R1/R2/R3/R4`, (32,24,16,63) if W=64 else (16,12,8,7), G rotation amounts (localparam).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `valid_i` in 1: a block is offered.
- `ready_o` out 1: the engine can accept a block.
- `first_i` in 1: the offered block is the first block of a message.
- `last_i` in 1: the offered block is the final block of a message.
- `len_i` in 8: byte count of the final block, 0..BB.
- `kk_i` in 8: key length in bytes; sampled on an accepted `first_i` block.
- `nn_i` in 8: digest length in bytes; sampled on an accepted `first_i` block.
- `d_i` in 16W: message words `m[0..15]`; `m[i] = d_i[W*i +: W]`.
- `valid_o` out 1: one-cycle pulse marking the final state.
- `h_o` out 8W: chained state `h[0..7]`; `h[i] = h_o[W*i +: W]`.

## Operation
- States:
  - IDLE: `ready_o=1`.
  - ROUND: `8R` cycles; sub-step `g=0..7` and round `r=0..R-1`.
  - FINAL: 1 cycle.
- IDLE→ROUND on `valid_i & ready_o`. ROUND→FINAL after `r=R-1`, `g=7`. FINAL→IDLE always.
- On accept:
  - `m_q <= d_i`.
  - `t_q <= (start ? 0 : t_q) + inc`, computed mod 2^(2W).
  - `inc = last_i ? min(len_i, BB) : BB`.
  - `start = first_i | ~chain_q`.
- When `start` is true, `h_q` is loaded with the IV, and `h0 ^= 0x01010000 ^ (kk<<8) ^ nn`.
- `chain_q` clears on reset and sets on the first accept.
  - A block accepted while `chain_q=0` is treated as first, even if `first_i=0`.
- `v` is initialised from `h_q`, IV, and the new `t_q`:
  - `v12 ^= t[W-1:0]`
  - `v13 ^= t[2W-1:W]`
  - `v14 ^= all-ones` when `last_i`.
- Round schedule:
  - Sub-steps `g=0..3` are the column G's, `g=4..7` the diagonal G's, per the standard index table.
  - Message words `x = m[σ[r mod 10][2g]]`, `y = m[σ[r mod 10][2g+1]]`.
  - Each G result is written back to `v_q` at the end of its cycle.
- FINAL: `h_q[i] <= h_q[i] ^ v[i] ^ v[i+8]`. If the block was marked last, `valid_o` pulses on the next cycle.
- `h_o` always drives `h_q`; it is stable from the `valid_o` pulse until the next accept.
- `valid_i` while `ready_o=0` is ignored; the source must hold the block.

## Timing
- Reset values:
  - `ready_o=1`, `valid_o=0`.
  - `h_q=0` (so `h_o=0`), `t_q=0`, `chain_q=0`, state IDLE.
- Accept at edge k. ROUND occupies cycles k+1..k+8R. FINAL occupies cycle k+8R+1.
- `ready_o` and `valid_o` (last blocks only) rise in cycle k+8R+2.
  - b: accept→`valid_o` is 98 cycles.
  - s: accept→`valid_o` is 82 cycles.
- Throughput: one block per 8R+2 cycles. Back-to-back accept is allowed in the cycle `ready_o` rises.
- `valid_o` is high for exactly one cycle, with no backpressure; the consumer must capture `h_o` before its next accept.
- Reset asserted mid-block aborts the block:
  - Registers return to reset values in the next cycle.
  - No `valid_o` is produced.
  - `ready_o=1` after reset deasserts.
- `first_i` and `last_i` both high is a single-block message.
- `first_i=1` mid-message, on a later block, restarts the chain and discards the prior state.
- `len_i=0` with `last_i` (empty message): `t` is unchanged, or 0 when `start`.

## Configuration
- `BLAKE2_KEYED_EN`:
  - Defined: `kk_i` is folded into `h0` as above; keyed hashing works when the upstream supplies the padded key block first.
  - Undefined: `kk_i` is ignored and treated as 0, and the key XOR logic is not built.

## Test plan
- W=64, single block `first_i=last_i=1`, `len_i=3`, `d_i="abc"` zero-padded, `nn_i=64` → `valid_o` 98 cycles after accept, `h_o[63:0]=64'h0D4D1C983FA580BA`.
- W=64, empty message `len_i=0`, `nn_i=64` → `h_o[63:0]=64'h03590142F7026A78`.
- W=32, "abc", `nn_i=32` → `valid_o` 82 cycles after accept, `h_o[31:0]=32'h8C5E8C50`.
- W=64, 200-byte message (block 0 full, block 1 with `last_i=1`, `len_i=72`):
  - No `valid_o` after block 0; `ready_o` returns after 98 cycles.
  - Final `h_o` matches the software model.
  - Internal `t` = 200.
- Reset asserted at cycle 40 of a block → `ready_o=1` and `valid_o=0` the next cycle. A following block with `first_i=0` is treated as first and gives the same digest as with `first_i=1`.
- `BLAKE2_KEYED_EN`, `kk_i=64`, key block then "abc" → digest matches the software keyed BLAKE2b. Without the macro the same stimulus matches the unkeyed hash of key‖"abc".
